quad_encoder_emulator: RTL and testbench

- Generates quadrature encoder signals (A/B channels plus a tick line) at a commanded shaft speed in RPM.
- It is the transmit-side counterpart of the encoder RPM measurement block. Used to drive the encoder inputs in loopback self-test and to emulate a motor encoder on the bench.
- Speed synthesis uses a phase accumulator (NCO), so no divider is needed. All outputs are registered on clk.

---
 rtl/quad_encoder_emulator.sv | 112 +++++++++++
 tb/tb_quad_encoder_emulator.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/quad_encoder_emulator.sv
`default_nettype none
// ============================================================================
// quad_encoder_emulator
// NCO-driven quadrature encoder source: A/B/tick outputs at a commanded RPM.
// Rev 1.0
// ============================================================================
module quad_encoder_emulator #(
  parameter int CLK_HZ = 50000000,
  parameter int CPR    = 256,
  parameter int ACC_W  = 34
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        dir,
  input  logic [15:0] rpm_cmd,
  output logic        enc_a,
  output logic        enc_b,
  output logic        ticks,
  output logic        step,
  output logic [31:0] position
);

  localparam logic [63:0]      TH_64 = 64'(CLK_HZ) * 64'd60;
  localparam logic [ACC_W-1:0] TH    = TH_64[ACC_W-1:0];
  localparam logic [ACC_W-1:0] CPR_W = ACC_W'(CPR);

  // Elaboration guards: one step per clock at full-scale rpm_cmd, whole
  // quadrature cycles per revolution, and room for acc+inc in ACC_W bits.
  generate
    if (64'(CPR) * 64'd65535 >= TH_64) begin : g_rate_check
      $error("quad_encoder_emulator: CPR*65535 must be below CLK_HZ*60");
    end
    if ((CPR % 4) != 0) begin : g_cpr_check
      $error("quad_encoder_emulator: CPR must be a multiple of 4");
    end
    if (((TH_64 << 1) >> ACC_W) != 64'd0) begin : g_width_check
      $error("quad_encoder_emulator: ACC_W too narrow for 2*CLK_HZ*60");
    end
  endgenerate

  // Encoding is {enc_a, enc_b}.
  typedef enum logic [1:0] {
    Q00 = 2'b00,
    Q10 = 2'b10,
    Q11 = 2'b11,
    Q01 = 2'b01
  } quad_e;

  quad_e             quad_q, quad_d;
  quad_e             quad_fwd, quad_rev;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              step_q, step_d;
  logic [31:0]       pos_q, pos_d;
  logic [ACC_W-1:0]  inc;
  logic [ACC_W-1:0]  acc_sum;

  assign inc     = ACC_W'(rpm_cmd) * CPR_W;
  assign acc_sum = acc_q + inc;

  always_comb begin
    quad_fwd = Q00;
    quad_rev = Q00;
    case (quad_q)
      Q00:     begin quad_fwd = Q10; quad_rev = Q01; end
      Q10:     begin quad_fwd = Q11; quad_rev = Q00; end
      Q11:     begin quad_fwd = Q01; quad_rev = Q10; end
      Q01:     begin quad_fwd = Q00; quad_rev = Q11; end
      default: begin quad_fwd = Q00; quad_rev = Q00; end
    endcase
  end

  always_comb begin
    acc_d  = acc_q;
    quad_d = quad_q;
    step_d = 1'b0;
    pos_d  = pos_q;
    if (!enable) begin
      acc_d = '0;
    end else if (acc_sum >= TH) begin
      // Remainder stays in acc so the long-term rate has no drift.
      acc_d  = acc_sum - TH;
      step_d = 1'b1;
      quad_d = dir ? quad_fwd : quad_rev;
      pos_d  = dir ? (pos_q + 32'd1) : (pos_q - 32'd1);
    end else begin
      acc_d = acc_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      quad_q <= Q00;
      step_q <= 1'b0;
      pos_q  <= '0;
    end else begin
      acc_q  <= acc_d;
      quad_q <= quad_d;
      step_q <= step_d;
      pos_q  <= pos_d;
    end
  end

  assign enc_a    = quad_q[1];
  assign enc_b    = quad_q[0];
  assign ticks    = quad_q[1];
  assign step     = step_q;
  assign position = pos_q;

endmodule
`default_nettype wire

// File: tb/tb_quad_encoder_emulator.sv
`default_nettype none
// ============================================================================
// tb_quad_encoder_emulator
// Directed self-checking bench for quad_encoder_emulator.
// Rev 1.0
// ============================================================================
module tb_quad_encoder_emulator;

  // A 1 kHz clock with CPR=4 would trip the one-step-per-clock guard, so the
  // clock is scaled to 4400 Hz (TH=264000); rpm 2640 gives TH/inc = 25 and
  // rpm 3080 gives TH/inc = 21.43, the same step ratios.
  localparam int CLK_HZ = 4400;
  localparam int CPR    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        dir;
  logic [15:0] rpm_cmd;
  logic        enc_a;
  logic        enc_b;
  logic        ticks;
  logic        step;
  logic [31:0] position;

  int   n_checks    = 0;
  int   n_errors    = 0;
  int   dbl_changes = 0;
  int   tick_rises  = 0;
  logic prev_a      = 1'b0;
  logic prev_b      = 1'b0;

  logic [1:0] fwd_seq [4] = '{2'b10, 2'b11, 2'b01, 2'b00};

  always #5 clk = ~clk;

  quad_encoder_emulator #(
    .CLK_HZ (CLK_HZ),
    .CPR    (CPR),
    .ACC_W  (34)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .dir      (dir),
    .rpm_cmd  (rpm_cmd),
    .enc_a    (enc_a),
    .enc_b    (enc_b),
    .ticks    (ticks),
    .step     (step),
    .position (position)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if ((enc_a != prev_a) && (enc_b != prev_b)) dbl_changes++;
    if (ticks && !prev_a) tick_rises++;
    prev_a = enc_a;
    prev_b = enc_b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    prev_a = enc_a;
    prev_b = enc_b;
    rst = 1'b0;
  endtask

  // Returns the edge count (1-based) at which step is seen, or -1.
  task automatic wait_step(input int max_edges, output int n);
    n = -1;
    for (int i = 1; i <= max_edges; i++) begin
      tick();
      if (step) begin
        n = i;
        return;
      end
    end
  endtask

  task automatic run_edges(input int n, output int steps);
    steps = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (step) steps++;
    end
  endtask

  initial begin
    int n;
    int steps;
    int last_edge;
    int min_iv;
    int max_iv;
    logic first;

    rst     = 1'b1;
    enable  = 1'b1;
    dir     = 1'b1;
    rpm_cmd = 16'd2640;

    // Reset overrides an active enable.
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_val("rst_ab",    {enc_a, enc_b}, 2'b00);
    check_val("rst_ticks", ticks, 1'b0);
    check_val("rst_step",  step, 1'b0);
    check_val("rst_pos",   position, 32'd0);
    prev_a = enc_a;
    prev_b = enc_b;
    rst = 1'b0;
    tick_rises = 0;

    // Forward at 25 clocks per step.
    for (int k = 0; k < 4; k++) begin
      wait_step(40, n);
      check_val("fwd_interval", n, 25);
      check_val("fwd_ab", {enc_a, enc_b}, fwd_seq[k]);
    end
    check_val("fwd_pos",   position, 32'd4);
    check_val("fwd_rises", tick_rises, 1);
    tick();
    check_val("step_pulse", step, 1'b0);

    // Fractional rate: 3000 clocks -> 140 steps, intervals 21 or 22.
    rpm_cmd = 16'd3080;
    do_reset();
    steps = 0; last_edge = 0; min_iv = 1000; max_iv = 0; first = 1'b1;
    for (int e = 1; e <= 3000; e++) begin
      tick();
      if (step) begin
        steps++;
        if (!first) begin
          if (e - last_edge < min_iv) min_iv = e - last_edge;
          if (e - last_edge > max_iv) max_iv = e - last_edge;
        end
        first = 1'b0;
        last_edge = e;
      end
    end
    check_val("frac_steps",  steps, 140);
    check_val("frac_pos",    position, 32'd140);
    check_val("frac_min_iv", min_iv, 21);
    check_val("frac_max_iv", max_iv, 22);

    // Direction reversal at state 11 retraces, and position wraps below 0.
    rpm_cmd = 16'd2640;
    do_reset();
    wait_step(40, n);
    wait_step(40, n);
    check_val("rev_pre_ab",  {enc_a, enc_b}, 2'b11);
    check_val("rev_pre_pos", position, 32'd2);
    dir = 1'b0;
    wait_step(40, n);
    check_val("rev_interval", n, 25);
    check_val("rev_ab1",  {enc_a, enc_b}, 2'b10);
    check_val("rev_pos1", position, 32'd1);
    wait_step(40, n);
    check_val("rev_ab2",  {enc_a, enc_b}, 2'b00);
    check_val("rev_pos2", position, 32'd0);
    wait_step(40, n);
    check_val("rev_ab3",  {enc_a, enc_b}, 2'b01);
    check_val("rev_pos3", position, 32'hFFFF_FFFF);

    // rpm 0 holds the residual; enable=0 freezes outputs and clears acc.
    dir = 1'b1;
    do_reset();
    wait_step(40, n);
    check_val("en_first", n, 25);
    run_edges(5, steps);
    rpm_cmd = 16'd0;
    run_edges(50, steps);
    check_val("zero_rpm_steps", steps, 0);
    rpm_cmd = 16'd2640;
    wait_step(40, n);
    check_val("residual_interval", n, 20);
    check_val("residual_ab", {enc_a, enc_b}, 2'b11);
    run_edges(10, steps);
    enable = 1'b0;
    run_edges(50, steps);
    check_val("dis_steps", steps, 0);
    check_val("dis_ab",    {enc_a, enc_b}, 2'b11);
    check_val("dis_pos",   position, 32'd2);
    enable = 1'b1;
    wait_step(40, n);
    check_val("reen_interval", n, 25);
    check_val("reen_ab",  {enc_a, enc_b}, 2'b01);
    check_val("reen_pos", position, 32'd3);

    // Reset mid-run at position 7, state 01, with enable held.
    do_reset();
    for (int k = 0; k < 7; k++) wait_step(40, n);
    check_val("mid_pre_ab",  {enc_a, enc_b}, 2'b01);
    check_val("mid_pre_pos", position, 32'd7);
    rst = 1'b1;
    tick();
    check_val("mid_rst_ab",   {enc_a, enc_b}, 2'b00);
    check_val("mid_rst_pos",  position, 32'd0);
    check_val("mid_rst_step", step, 1'b0);
    rst = 1'b0;
    wait_step(40, n);
    check_val("mid_first", n, 25);
    check_val("mid_ab", {enc_a, enc_b}, 2'b10);

    check_val("one_bit_change", dbl_changes, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
